cosim_buffered_endpoint: RTL and testbench
==========================================

// Module: cosim_buffered_endpoint
// PURPOSE
//   Next-generation cosim <-> DPI bridge for one ESI endpoint. Adds parametrised FIFO buffering
//   in both directions and a true valid/ready handshake (no data loss on backpressure).
//   Adds bounded retry of failed host puts, plus status/error counters.
//   Sits between an ESI channel port in RTL and the cosim DPI calls cosim_ep_register, cosim_ep_tryget, cosim_ep_tryput.
// PARAMETERS
//   ENDPOINT_ID     (none)  cosim endpoint id passed to every DPI call
//   ESI_TYPE_ID     (none)  64-bit ESI type id passed to cosim_ep_register
//   TYPE_SIZE_BITS  (none)  message width in bits, >= 1
//   OUT_DEPTH       4       host->RTL FIFO entries, power of 2, >= 2
//   IN_DEPTH        4       RTL->host FIFO entries, power of 2, >= 2
//   MAX_RETRIES     8       consecutive failed tryput attempts before the head entry is dropped
// PORTS
//   clk            in   1               clock
//   rst            in   1               synchronous reset, active high
//   DataOutValid   out  1               host->RTL message available at FIFO head
//   DataOutReady   in   1               consumer accepts DataOut this cycle
//   DataOut        out  TYPE_SIZE_BITS  host->RTL message
//   DataInValid    in   1               producer offers DataIn this cycle
//   DataInReady    out  1               RTL->host FIFO can accept this cycle
//   DataIn         in   TYPE_SIZE_BITS  RTL->host message
//   Registered     out  1               endpoint registered and running
//   ErrorCount     out  16              DPI error returns, saturating
//   DropCount      out  16              RTL->host messages dropped after MAX_RETRIES, saturating
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high (rst). All state updates on posedge clk.
//   - Reset values: DataOutValid=0, DataInReady=0, Registered=0, ErrorCount=0, DropCount=0, both FIFOs empty.
//   - Byte mapping:
//     - TYPE_SIZE_BYTES = (TYPE_SIZE_BITS+7)/8.
//     - Byte i holds bits [8i+7:8i], little-endian.
//     - Unused top bits are ignored on get and sent as 0 on put.
//   - FSM:
//     - RESET -> REGISTER on the first cycle with rst=0.
//     - REGISTER calls cosim_ep_register exactly once per simulation:
//       - rc==0 -> RUN.
//       - rc!=0 -> ERROR, ErrorCount+1.
//     - ERROR is terminal until rst: DataInReady=0, DataOutValid=0.
//     - Registration is remembered across rst. A reset after successful registration flushes FIFOs
//       and clears counters, then goes RESET -> RUN directly (no second register call).
//   - Registered=1 only in RUN.
//   - Outbound (host->RTL):
//     - In RUN, each cycle the out FIFO is not full at the clock edge, call cosim_ep_tryget with a TYPE_SIZE_BYTES limit.
//     - rc==0 with limit unchanged: push the message; it is visible on DataOut/DataOutValid the next cycle (1-cycle latency).
//     - rc==0 with limit 0: no message, no push.
//     - rc<0, rc>0, or a partial length: ErrorCount+1, nothing pushed.
//     - FIFO full: no tryget that cycle, even if a pop occurs in the same cycle.
//     - Head pops when DataOutValid & DataOutReady. DataOut is stable while DataOutValid=1 and no pop.
//     - Simultaneous push and pop are allowed; occupancy is unchanged.
//   - Inbound (RTL->host):
//     - DataInReady = RUN & !in_full, combinational from the registered count.
//     - DataIn is pushed when DataInValid & DataInReady.
//     - In RUN with the FIFO non-empty, call cosim_ep_tryput on the head each cycle.
//       - rc==0: pop the head, clear the retry counter.
//       - rc!=0: keep the head, ErrorCount+1, retry counter+1.
//       - MAX_RETRIES consecutive failures: pop and discard, DropCount+1, clear the retry counter.
//     - Push and pop may occur in the same cycle, including when the FIFO is full. Ready is still 0 at full, so no push then.
//   - FIFO pointers wrap modulo depth. Full/empty come from a separate count register (0..DEPTH).
//   - Counters saturate at 16'hFFFF.
//   - rst asserted mid-transfer: in-flight FIFO contents are discarded and no DPI call is made that cycle.
// TESTING
//   - TYPE_SIZE_BITS=12; host sends bytes {8'hAB,8'hFC} -> DataOut=12'hCAB, DataOutValid one cycle after the tryget cycle.
//   - DataOutReady=0 while host sends 6 msgs, OUT_DEPTH=4 -> 4 buffered, tryget stops; release ready -> all 6 delivered in order, none lost.
//   - Stream 10 DataIn msgs, IN_DEPTH=4, tryput succeeding -> DataInReady never low more than 1 cycle; host receives 10 msgs in order.
//   - tryput stubbed to fail forever, MAX_RETRIES=8 -> head dropped after 8 attempts, DropCount=1, ErrorCount=8, next msg attempted.
//   - cosim_ep_register returns -1 -> ERROR, Registered=0, ErrorCount=1, DataInReady=0 permanently until rst.
//   - Pulse rst with 3 msgs queued each way -> FIFOs empty, counters 0, no second register call, Registered=1 two cycles after rst falls.

Source files
------------

// File: rtl/cosim_buffered_endpoint.sv
// Buffered cosim endpoint: host<->RTL FIFOs with valid/ready handshakes, bounded put retry and
// saturating error/drop counters. cosim_dpi_pkg is the host call surface (in-simulation host stand-in).

package cosim_dpi_pkg;
   localparam int MAX_MSG_BITS = 256;
   typedef logic [MAX_MSG_BITS-1:0] msg_t;
   typedef struct packed {
      int   rc;
      int   len;
      msg_t data;
   } get_t;

   get_t   get_q[$];
   msg_t   put_q[$];
   int     fail_register_ep = -1;
   bit     put_fail = 1'b0;
   int     register_calls = 0;
   int     put_calls = 0;
   int     last_ep = 0;
   longint last_type_id = 0;
   int     last_type_size = 0;
   int     last_put_size = 0;
   msg_t   last_put_data = '0;

   function automatic int cosim_ep_register(input int ep, input longint type_id, input int type_size);
      register_calls++;
      last_ep = ep;
      last_type_id = type_id;
      last_type_size = type_size;
      return (ep == fail_register_ep) ? -1 : 0;
   endfunction

   // size carries the byte limit in and the delivered length out (0 = nothing pending).
   function automatic int cosim_ep_tryget(input int ep, output msg_t data, inout int size);
      get_t e;
      last_ep = ep;
      data = '0;
      if (get_q.size() == 0) begin
         size = 0;
         return 0;
      end
      e = get_q.pop_front();
      data = e.data;
      if (e.len < size) size = e.len;
      return e.rc;
   endfunction

   function automatic int cosim_ep_tryput(input int ep, input msg_t data, input int size);
      put_calls++;
      last_ep = ep;
      last_put_data = data;
      last_put_size = size;
      if (put_fail) return -1;
      put_q.push_back(data);
      return 0;
   endfunction

   function automatic void host_send(input logic [63:0] data, input int len, input int rc);
      get_t e;
      e.rc = rc;
      e.len = len;
      e.data = msg_t'(data);
      get_q.push_back(e);
   endfunction

   function automatic int host_get_count();
      return get_q.size();
   endfunction

   function automatic int host_put_count();
      return put_q.size();
   endfunction

   function automatic msg_t host_pop_put();
      return put_q.pop_front();
   endfunction

   function automatic void set_put_fail(input bit f);
      put_fail = f;
   endfunction

   function automatic void set_register_fail(input int ep);
      fail_register_ep = ep;
   endfunction
endpackage

module cosim_buffered_endpoint
   import cosim_dpi_pkg::*;
#(
   parameter int          ENDPOINT_ID    = 0,
   parameter logic [63:0] ESI_TYPE_ID    = 64'd0,
   parameter int          TYPE_SIZE_BITS = 8,
   parameter int          OUT_DEPTH      = 4,
   parameter int          IN_DEPTH       = 4,
   parameter int          MAX_RETRIES    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      DataOutValid,
   input  logic                      DataOutReady,
   output logic [TYPE_SIZE_BITS-1:0] DataOut,
   input  logic                      DataInValid,
   output logic                      DataInReady,
   input  logic [TYPE_SIZE_BITS-1:0] DataIn,
   output logic                      Registered,
   output logic [15:0]               ErrorCount,
   output logic [15:0]               DropCount
);
   localparam int TYPE_SIZE_BYTES = (TYPE_SIZE_BITS + 7) / 8;
   localparam int OAW = $clog2(OUT_DEPTH);
   localparam int IAW = $clog2(IN_DEPTH);
   localparam int RW  = $clog2(MAX_RETRIES + 1);
   localparam logic [OAW:0]  OUT_FULL   = (OAW+1)'(OUT_DEPTH);
   localparam logic [IAW:0]  IN_FULL    = (IAW+1)'(IN_DEPTH);
   localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);

   localparam logic [1:0] S_RESET    = 2'd0;
   localparam logic [1:0] S_REGISTER = 2'd1;
   localparam logic [1:0] S_RUN      = 2'd2;
   localparam logic [1:0] S_ERROR    = 2'd3;

   logic [1:0] state;
   // Registration outcome survives rst so the host sees exactly one register call.
   logic reg_tried = 1'b0;
   logic reg_ok    = 1'b0;

   logic [TYPE_SIZE_BITS-1:0] out_mem [OUT_DEPTH];
   logic [OAW-1:0]            out_rd, out_wr;
   logic [OAW:0]              out_cnt;
   logic [TYPE_SIZE_BITS-1:0] in_mem [IN_DEPTH];
   logic [IAW-1:0]            in_rd, in_wr;
   logic [IAW:0]              in_cnt;
   logic [RW-1:0]             retry_cnt;
   logic                      out_pop, in_push;

   // Handshake: a beat transfers on any rising edge where valid and ready are both high.
   assign Registered   = (state == S_RUN);
   assign DataOutValid = (state == S_RUN) && (out_cnt != '0);
   assign DataOut      = out_mem[out_rd];
   assign DataInReady  = (state == S_RUN) && (in_cnt != IN_FULL);
   assign out_pop      = DataOutValid & DataOutReady;
   assign in_push      = DataInValid & DataInReady;

   function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] n);
      logic [16:0] s;
      s = {1'b0, c} + 17'(n);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   always_ff @(posedge clk) begin
      int         rc;
      int         get_size;
      msg_t       get_data;
      logic       push_out;
      logic       pop_in;
      logic       drop;
      logic [1:0] err_inc;
      rc       = 0;
      get_size = 0;
      get_data = '0;
      push_out = 1'b0;
      pop_in   = 1'b0;
      drop     = 1'b0;
      err_inc  = 2'd0;
      if (rst) begin
         state      <= S_RESET;
         out_rd     <= '0;
         out_wr     <= '0;
         out_cnt    <= '0;
         in_rd      <= '0;
         in_wr      <= '0;
         in_cnt     <= '0;
         retry_cnt  <= '0;
         ErrorCount <= '0;
         DropCount  <= '0;
      end else begin
         case (state)
            S_RESET: state <= reg_ok ? S_RUN : (reg_tried ? S_ERROR : S_REGISTER);
            S_REGISTER: begin
               rc = cosim_ep_register(ENDPOINT_ID, longint'(ESI_TYPE_ID), TYPE_SIZE_BYTES);
               reg_tried <= 1'b1;
               if (rc == 0) begin
                  reg_ok <= 1'b1;
                  state  <= S_RUN;
               end else begin
                  err_inc = 2'd1;
                  state   <= S_ERROR;
               end
            end
            S_RUN: begin
               // Fullness is judged before any same-cycle pop.
               if (out_cnt != OUT_FULL) begin
                  get_size = TYPE_SIZE_BYTES;
                  rc = cosim_ep_tryget(ENDPOINT_ID, get_data, get_size);
                  if (rc == 0 && get_size == TYPE_SIZE_BYTES) push_out = 1'b1;
                  else if (!(rc == 0 && get_size == 0)) err_inc = err_inc + 2'd1;
               end
               if (in_cnt != '0) begin
                  rc = cosim_ep_tryput(ENDPOINT_ID, msg_t'(in_mem[in_rd]), TYPE_SIZE_BYTES);
                  if (rc == 0) begin
                     pop_in = 1'b1;
                     retry_cnt <= '0;
                  end else begin
                     err_inc = err_inc + 2'd1;
                     if (retry_cnt == RETRY_LAST) begin
                        pop_in = 1'b1;
                        drop   = 1'b1;
                        retry_cnt <= '0;
                     end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase

         if (push_out) begin
            out_mem[out_wr] <= get_data[TYPE_SIZE_BITS-1:0];
            out_wr <= out_wr + 1'b1;
         end
         if (out_pop) out_rd <= out_rd + 1'b1;
         if (push_out && !out_pop) out_cnt <= out_cnt + 1'b1;
         else if (!push_out && out_pop) out_cnt <= out_cnt - 1'b1;

         if (in_push) begin
            in_mem[in_wr] <= DataIn;
            in_wr <= in_wr + 1'b1;
         end
         if (pop_in) in_rd <= in_rd + 1'b1;
         if (in_push && !pop_in) in_cnt <= in_cnt + 1'b1;
         else if (!in_push && pop_in) in_cnt <= in_cnt - 1'b1;

         ErrorCount <= sat_add(ErrorCount, err_inc);
         if (drop) DropCount <= sat_add(DropCount, 2'd1);
      end
   end
endmodule

// File: tb/tb_cosim_buffered_endpoint.sv
// Bench for cosim_buffered_endpoint: directed host/RTL traffic with queue-based scoreboards on both
// directions, plus a second instance whose registration is refused by the host.

module tb_cosim_buffered_endpoint;
   import cosim_dpi_pkg::*;
   localparam int W = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          DataOutValid, DataOutReady, DataInValid, DataInReady, Registered;
   logic [W-1:0]  DataOut, DataIn;
   logic [15:0]   ErrorCount, DropCount;
   logic          e_DataOutValid, e_DataInReady, e_Registered;
   logic          e_DataOutReady = 1'b1;
   logic          e_DataInValid = 1'b1;
   logic [W-1:0]  e_DataOut;
   logic [W-1:0]  e_DataIn = 12'h5A5;
   logic [15:0]   e_ErrorCount, e_DropCount;

   int total = 0;
   int bad = 0;
   logic [W-1:0] out_exp_q[$];
   logic [W-1:0] in_exp_q[$];

   logic [15:0] t2_raw [6] = '{16'hA111, 16'hB222, 16'hC333, 16'hD444, 16'hE555, 16'hF666};
   logic [W-1:0] t2_exp [6] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666};

   always #5 clk = ~clk;

   cosim_buffered_endpoint #(
      .ENDPOINT_ID(1), .ESI_TYPE_ID(64'h00C0_FFEE_0000_0012), .TYPE_SIZE_BITS(W),
      .OUT_DEPTH(4), .IN_DEPTH(4), .MAX_RETRIES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .DataOutValid(DataOutValid), .DataOutReady(DataOutReady), .DataOut(DataOut),
      .DataInValid(DataInValid), .DataInReady(DataInReady), .DataIn(DataIn),
      .Registered(Registered), .ErrorCount(ErrorCount), .DropCount(DropCount)
   );

   cosim_buffered_endpoint #(
      .ENDPOINT_ID(7), .ESI_TYPE_ID(64'h00C0_FFEE_0000_0012), .TYPE_SIZE_BITS(W),
      .OUT_DEPTH(4), .IN_DEPTH(4), .MAX_RETRIES(8)
   ) dut_err (
      .clk(clk), .rst(rst),
      .DataOutValid(e_DataOutValid), .DataOutReady(e_DataOutReady), .DataOut(e_DataOut),
      .DataInValid(e_DataInValid), .DataInReady(e_DataInReady), .DataIn(e_DataIn),
      .Registered(e_Registered), .ErrorCount(e_ErrorCount), .DropCount(e_DropCount)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: consumes every DataOut beat and every message the host receives.
   always @(negedge clk) begin
      msg_t         d;
      logic [W-1:0] e;
      if (DataOutValid && DataOutReady) begin
         if (out_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_unexpected: got 0x%0h want nothing", DataOut);
         end else begin
            e = out_exp_q.pop_front();
            check("out_data", 64'(DataOut), 64'(e));
         end
      end
      while (host_put_count() > 0) begin
         d = host_pop_put();
         if (in_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL put_unexpected: got 0x%0h want nothing", d[63:0]);
         end else begin
            e = in_exp_q.pop_front();
            check("put_data", d[63:0], 64'(e));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_in(input logic [W-1:0] v, input bit expect_put, output int stalls);
      int guard;
      guard = 0;
      stalls = 0;
      DataInValid = 1'b1;
      DataIn = v;
      @(negedge clk);
      while (!DataInReady && guard < 40) begin
         stalls++;
         guard++;
         @(negedge clk);
      end
      if (!DataInReady) begin
         total++;
         bad++;
         $display("FAIL in_ready_timeout: got ready=0 want ready=1 for 0x%0h", v);
      end else if (expect_put) begin
         in_exp_q.push_back(v);
      end
      @(posedge clk);
      #1;
      DataInValid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int guard;
      guard = 0;
      while ((out_exp_q.size() != 0 || in_exp_q.size() != 0) && guard < 60) begin
         tick(1);
         guard++;
      end
      check(name, 64'(out_exp_q.size() + in_exp_q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int max_st;
      int calls0;
      int guard;
      DataOutReady = 1'b0;
      DataInValid  = 1'b0;
      DataIn       = '0;
      set_register_fail(7);
      rst = 1'b1;
      tick(3);
      check("rst_out_valid", 64'(DataOutValid), 64'd0);
      check("rst_in_ready", 64'(DataInReady), 64'd0);
      check("rst_registered", 64'(Registered), 64'd0);
      check("rst_err", 64'(ErrorCount), 64'd0);
      check("rst_drop", 64'(DropCount), 64'd0);
      rst = 1'b0;
      tick(3);
      check("reg_up", 64'(Registered), 64'd1);
      check("reg_in_ready", 64'(DataInReady), 64'd1);
      check("reg_calls", 64'(register_calls), 64'd2);
      check("reg_type_size", 64'(last_type_size), 64'd2);
      check("err_registered", 64'(e_Registered), 64'd0);
      check("err_count", 64'(e_ErrorCount), 64'd1);
      check("err_in_ready", 64'(e_DataInReady), 64'd0);
      check("err_out_valid", 64'(e_DataOutValid), 64'd0);

      // Byte mapping and one-cycle get latency.
      host_send(64'hFCAB, 2, 0);
      check("t1_pre_valid", 64'(DataOutValid), 64'd0);
      tick(1);
      check("t1_valid", 64'(DataOutValid), 64'd1);
      check("t1_data", 64'(DataOut), 64'hCAB);
      out_exp_q.push_back(12'hCAB);
      DataOutReady = 1'b1;
      tick(1);
      check("t1_drained", 64'(DataOutValid), 64'd0);

      // Backpressure: six messages, four-entry FIFO.
      DataOutReady = 1'b0;
      for (int i = 0; i < 6; i++) begin
         host_send(64'(t2_raw[i]), 2, 0);
         out_exp_q.push_back(t2_exp[i]);
      end
      tick(8);
      check("t2_host_left", 64'(host_get_count()), 64'd2);
      check("t2_valid", 64'(DataOutValid), 64'd1);
      check("t2_head_stable", 64'(DataOut), 64'h111);
      DataOutReady = 1'b1;
      wait_drain("t2_drain");
      check("t2_host_empty", 64'(host_get_count()), 64'd0);

      // Bad gets: partial length, negative rc, empty message, then a good one.
      host_send(64'h0123, 1, 0);
      host_send(64'h0456, 2, -2);
      host_send(64'h0999, 0, 0);
      host_send(64'h0BCD, 2, 0);
      out_exp_q.push_back(12'hBCD);
      wait_drain("t2b_drain");
      check("t2b_err", 64'(ErrorCount), 64'd2);

      // Streaming inbound with a cooperative host.
      max_st = 0;
      for (int i = 0; i < 10; i++) begin
         send_in(12'(12'h301 + i), 1'b1, st);
         if (st > max_st) max_st = st;
      end
      check("t3_max_stall_le1", 64'(max_st <= 1), 64'd1);
      wait_drain("t3_drain");

      // Host refuses every put: head is dropped after eight attempts.
      set_put_fail(1'b1);
      calls0 = put_calls;
      send_in(12'h7A5, 1'b0, st);
      guard = 0;
      while (DropCount != 16'd1 && guard < 40) begin
         tick(1);
         guard++;
      end
      check("t4_drop", 64'(DropCount), 64'd1);
      check("t4_err", 64'(ErrorCount), 64'd10);
      check("t4_attempts", 64'(put_calls - calls0), 64'd8);
      calls0 = put_calls;
      send_in(12'h7B6, 1'b1, st);
      tick(2);
      check("t4_next_data", last_put_data[63:0], 64'h7B6);
      check("t4_next_tried", 64'(put_calls > calls0), 64'd1);
      set_put_fail(1'b0);
      wait_drain("t4_drain");

      // Reset with three messages queued in each direction.
      DataOutReady = 1'b0;
      host_send(64'h0AAA, 2, 0);
      host_send(64'h0BBB, 2, 0);
      host_send(64'h0CCC, 2, 0);
      set_put_fail(1'b1);
      send_in(12'h111, 1'b0, st);
      send_in(12'h222, 1'b0, st);
      send_in(12'h333, 1'b0, st);
      check("t6_pre_valid", 64'(DataOutValid), 64'd1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      set_put_fail(1'b0);
      check("t6_out_valid", 64'(DataOutValid), 64'd0);
      check("t6_in_ready", 64'(DataInReady), 64'd0);
      check("t6_err", 64'(ErrorCount), 64'd0);
      check("t6_drop", 64'(DropCount), 64'd0);
      check("t6_reg_low", 64'(Registered), 64'd0);
      tick(2);
      check("t6_reg_up", 64'(Registered), 64'd1);
      check("t6_fifo_empty", 64'(DataOutValid), 64'd0);
      check("t6_in_ready_up", 64'(DataInReady), 64'd1);
      check("t6_reg_calls", 64'(register_calls), 64'd2);
      check("t6_err_inst_ready", 64'(e_DataInReady), 64'd0);
      tick(5);
      check("final_queues", 64'(out_exp_q.size() + in_exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
